// File: rtl/fc_pkg.sv
// Shared types and the post-accumulation arithmetic for the fully-connected layer engine.
// Latency: n/a (package: state encoding and a combinational rounding/saturation helper).
// Backpressure: n/a.
package fc_pkg;

  // Working width of the rounding helper; accumulators are sign-extended into it.
  localparam int ACC_MAX_W = 64;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_IN,
    LOAD_BIAS,
    MAC,
    POST,
    DRAIN,
    FIN
  } state_t;

  // Round half up, saturate to a dwidth-bit signed word, then optionally apply ReLU.
  // The caller truncates the result to dwidth bits; the value always fits after saturation.
  function automatic logic signed [ACC_MAX_W-1:0] round_sat_act(
    input logic signed [ACC_MAX_W-1:0] acc,
    input logic                        mode,
    input int                          dwidth,
    input int                          frac
  );
    logic signed [ACC_MAX_W-1:0] r;
    logic signed [ACC_MAX_W-1:0] hi;
    logic signed [ACC_MAX_W-1:0] lo;
    r  = (acc + (64'sd1 <<< (frac - 1))) >>> frac;
    hi = (64'sd1 <<< (dwidth - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dwidth - 1));
    if (r > hi) begin
      r = hi;
    end else if (r < lo) begin
      r = lo;
    end
    if (mode && (r < 64'sd0)) begin
      r = 64'sd0;
    end
    return r;
  endfunction

endpackage

// File: rtl/fc_mac_lane.sv
// One neuron lane: bias preload, multiply-accumulate over the input vector, rounded result register.
// Latency: accumulator updates on the enabling edge; res is valid the cycle after post_en.
// Backpressure: none internally; the sequencer only pulses the enables on completed handshakes.
module fc_mac_lane import fc_pkg::*; #(
  parameter int DWIDTH    = 16,
  parameter int FRAC      = 10,
  parameter int ACC_WIDTH = 39
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     bias_load,
  input  logic signed [DWIDTH-1:0] bias,
  input  logic                     mac_en,
  input  logic signed [DWIDTH-1:0] x,
  input  logic signed [DWIDTH-1:0] w,
  input  logic                     post_en,
  input  logic                     mode,
  output logic        [DWIDTH-1:0] res
);

  logic signed [2*DWIDTH-1:0]  prod;
  logic signed [ACC_WIDTH-1:0] acc;

  // Full-precision product so no bits are lost before accumulation.
  assign prod = x * w;

  // Accumulator: bias preloaded in the same Q format as the products, then summed; result captured in POST.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc <= '0;
      res <= '0;
    end else begin
      if (bias_load) begin
        acc <= ACC_WIDTH'(bias) <<< FRAC;
      end else if (mac_en) begin
        acc <= acc + ACC_WIDTH'(prod);
      end
      if (post_en) begin
        res <= DWIDTH'(round_sat_act(ACC_MAX_W'(acc), mode, DWIDTH, FRAC));
      end
    end
  end

endmodule

// File: rtl/fc_layer_engine.sv
// Fully-connected layer: loads one input vector, then per group of NUM_LANES neurons takes a bias beat and IN_SIZE weight beats.
// Latency: out_valid rises two cycles after the last weight handshake of a group; done pulses the cycle after the final result.
// Backpressure: exactly one of in/b/w/out handshakes is open per state; the engine holds all state while its open side stalls.
module fc_layer_engine import fc_pkg::*; #(
  parameter int DWIDTH      = 16,
  parameter int FRAC        = 10,
  parameter int IN_SIZE     = 64,
  parameter int NUM_NEURONS = 16,
  parameter int NUM_LANES   = 4,
  parameter int ACC_WIDTH   = 2*DWIDTH + $clog2(IN_SIZE) + 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           mode,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [DWIDTH-1:0]              in_data,
  input  logic                           b_valid,
  output logic                           b_ready,
  input  logic [NUM_LANES*DWIDTH-1:0]    b_data,
  input  logic                           w_valid,
  output logic                           w_ready,
  input  logic [NUM_LANES*DWIDTH-1:0]    w_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [DWIDTH-1:0]              out_data,
  output logic [$clog2(NUM_NEURONS)-1:0] out_idx,
  output logic                           busy,
  output logic                           done
);

  localparam int GROUPS = NUM_NEURONS / NUM_LANES;
  localparam int KW     = $clog2(IN_SIZE);
  localparam int GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam int LW     = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int IW     = $clog2(NUM_NEURONS);

  if (NUM_NEURONS % NUM_LANES != 0) begin : g_chk_groups
    $error("fc_layer_engine: NUM_NEURONS must be a multiple of NUM_LANES");
  end
  if (FRAC < 1 || FRAC >= DWIDTH) begin : g_chk_frac
    $error("fc_layer_engine: FRAC must satisfy 1 <= FRAC < DWIDTH");
  end
  if (ACC_WIDTH > ACC_MAX_W) begin : g_chk_acc
    $error("fc_layer_engine: ACC_WIDTH exceeds the rounding helper width");
  end

  state_t                   state;
  logic                     mode_q;
  logic [KW-1:0]            k;
  logic [GW-1:0]            g;
  logic [LW-1:0]            lane;
  logic signed [DWIDTH-1:0] x_mem [IN_SIZE];
  logic signed [DWIDTH-1:0] x_cur;
  logic [DWIDTH-1:0]        res_arr [NUM_LANES];
  logic                     bias_fire;
  logic                     w_fire;
  logic                     post_en;

  assign bias_fire = b_valid && b_ready;
  assign w_fire    = w_valid && w_ready;
  assign post_en   = (state == POST);
  assign x_cur     = x_mem[k];
  assign out_data  = res_arr[lane];
  assign out_idx   = IW'(int'(g) * NUM_LANES + int'(lane));

  // Input vector storage; contents only matter between LOAD_IN and the end of the layer.
  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      x_mem[k] <= in_data;
    end
  end

  // Layer sequencer: state, counters and registered handshake/status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      mode_q    <= 1'b0;
      k         <= '0;
      g         <= '0;
      lane      <= '0;
      in_ready  <= 1'b0;
      b_ready   <= 1'b0;
      w_ready   <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mode_q   <= mode;
            g        <= '0;
            k        <= '0;
            lane     <= '0;
            in_ready <= 1'b1;
            busy     <= 1'b1;
            state    <= LOAD_IN;
          end
        end
        LOAD_IN: begin
          if (in_valid) begin
            if (k == KW'(IN_SIZE - 1)) begin
              k        <= '0;
              in_ready <= 1'b0;
              b_ready  <= 1'b1;
              state    <= LOAD_BIAS;
            end else begin
              k <= k + KW'(1);
            end
          end
        end
        LOAD_BIAS: begin
          if (b_valid) begin
            k       <= '0;
            b_ready <= 1'b0;
            w_ready <= 1'b1;
            state   <= MAC;
          end
        end
        MAC: begin
          if (w_valid) begin
            if (k == KW'(IN_SIZE - 1)) begin
              k       <= '0;
              w_ready <= 1'b0;
              state   <= POST;
            end else begin
              k <= k + KW'(1);
            end
          end
        end
        POST: begin
          lane      <= '0;
          out_valid <= 1'b1;
          state     <= DRAIN;
        end
        DRAIN: begin
          if (out_ready) begin
            if (lane == LW'(NUM_LANES - 1)) begin
              lane      <= '0;
              out_valid <= 1'b0;
              if (g == GW'(GROUPS - 1)) begin
                g     <= '0;
                done  <= 1'b1;
                state <= FIN;
              end else begin
                g       <= g + GW'(1);
                b_ready <= 1'b1;
                state   <= LOAD_BIAS;
              end
            end else begin
              lane <= lane + LW'(1);
            end
          end
        end
        FIN: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          in_ready  <= 1'b0;
          b_ready   <= 1'b0;
          w_ready   <= 1'b0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    fc_mac_lane #(
      .DWIDTH    (DWIDTH),
      .FRAC      (FRAC),
      .ACC_WIDTH (ACC_WIDTH)
    ) u_lane (
      .clk       (clk),
      .reset     (reset),
      .bias_load (bias_fire),
      .bias      (b_data[l*DWIDTH +: DWIDTH]),
      .mac_en    (w_fire),
      .x         (x_cur),
      .w         (w_data[l*DWIDTH +: DWIDTH]),
      .post_en   (post_en),
      .mode      (mode_q),
      .res       (res_arr[l])
    );
  end

endmodule

// File: tb/tb_fc_layer_engine.sv
// Directed bench for fc_layer_engine: hand-computed layer results, saturation, ReLU, rounding, stalls, abort.
// Latency: checks total layer cycle count against the closed-form figure, with and without stalls.
// Backpressure: exercises w_valid gaps and out_ready hold-offs, checking output stability.
module tb_fc_layer_engine;

  localparam int DW       = 16;
  localparam int IN       = 64;
  localparam int NN       = 16;
  localparam int NL       = 4;
  localparam int G        = NN / NL;
  localparam int BASE_CYC = IN + G * (1 + IN + 1 + NL) + 2;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 start;
  logic                 mode;
  logic                 in_valid;
  logic                 in_ready;
  logic [DW-1:0]        in_data;
  logic                 b_valid;
  logic                 b_ready;
  logic [NL*DW-1:0]     b_data;
  logic                 w_valid;
  logic                 w_ready;
  logic [NL*DW-1:0]     w_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [DW-1:0]        out_data;
  logic [3:0]           out_idx;
  logic                 busy;
  logic                 done;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] got_data [NN];
  logic [3:0]    got_idx  [NN];
  int            got_n;
  int            got_done;
  int            got_cyc;
  int            got_stall;
  int            got_unstable;
  bit            got_timeout;

  always #5 clk = ~clk;

  fc_layer_engine dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .b_valid   (b_valid),
    .b_ready   (b_ready),
    .b_data    (b_data),
    .w_valid   (w_valid),
    .w_ready   (w_ready),
    .w_data    (w_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .busy      (busy),
    .done      (done)
  );

  // Drive one whole layer with constant weights/biases; x[0]=x0, the rest xr. Collects results and stats.
  task automatic run_layer(input logic md, input logic [15:0] x0, input logic [15:0] xr,
                           input logic [15:0] wv, input logic [15:0] bv,
                           input bit wgap, input int ostall);
    int            xk = 0;
    int            hold = 0;
    int            budget = 0;
    bit            fin = 0;
    logic [15:0]   hd = '0;
    logic [3:0]    hi = '0;
    got_n = 0; got_done = 0; got_cyc = 0; got_stall = 0; got_unstable = 0; got_timeout = 0;
    b_data = {NL{bv}}; w_data = {NL{wv}};
    in_valid = 1'b1; b_valid = 1'b1; w_valid = 1'b1; out_ready = 1'b0;
    in_data = x0;
    @(negedge clk); start = 1'b1; mode = md;
    @(negedge clk); start = 1'b0; mode = ~md;
    while (!fin && budget < 3000) begin
      budget++;
      if (busy) got_cyc++;
      if (done) begin got_done++; fin = 1; end
      in_data = (xk == 0) ? x0 : xr;
      if (in_ready) xk++;
      if (w_ready && wgap && ($urandom_range(0, 2) == 0)) begin
        w_valid = 1'b0; got_stall++;
      end else begin
        w_valid = 1'b1;
      end
      out_ready = 1'b0;
      if (out_valid) begin
        if (hold == 0) begin
          hd = out_data; hi = out_idx;
        end else if (out_data !== hd || out_idx !== hi) begin
          got_unstable++;
        end
        if (hold < ostall) begin
          hold++; got_stall++;
        end else begin
          out_ready = 1'b1;
          if (got_n < NN) begin got_data[got_n] = out_data; got_idx[got_n] = out_idx; end
          got_n++;
          hold = 0;
        end
      end
      if (!fin) @(negedge clk);
    end
    if (!fin) got_timeout = 1;
    in_valid = 1'b0; b_valid = 1'b0; w_valid = 1'b0; out_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done) got_done++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; mode = 1'b0; in_valid = 1'b0; in_data = '0;
    b_valid = 1'b0; b_data = '0; w_valid = 1'b0; w_data = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({in_ready, b_ready, w_ready, out_valid, busy, done, out_data, out_idx} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: in_rdy=%0b b_rdy=%0b w_rdy=%0b out_vld=%0b busy=%0b done=%0b data=%0h idx=%0d, all required 0",
               in_ready, b_ready, w_ready, out_valid, busy, done, out_data, out_idx);
    end
  endtask

  task automatic test_linear();
    run_layer(1'b0, 16'd1024, 16'd1024, 16'd64, 16'd0, 1'b0, 0);
    for (int i = 0; i < NN; i++) begin
      checks++;
      if (got_data[i] !== 16'd4096 || got_idx[i] !== 4'(i)) begin
        errors++;
        $display("FAIL linear_out[%0d]: got %0d idx %0d, required 4096 idx %0d", i, got_data[i], got_idx[i], i);
      end
    end
    checks++;
    if (got_timeout || got_n !== NN) begin
      errors++; $display("FAIL linear_count: got %0d results timeout=%0b, required %0d", got_n, got_timeout, NN);
    end
    checks++;
    if (got_done !== 1) begin
      errors++; $display("FAIL linear_done: got %0d done pulses, required 1", got_done);
    end
    checks++;
    if (got_cyc + 1 !== BASE_CYC) begin
      errors++; $display("FAIL linear_cycles: got %0d, required %0d", got_cyc + 1, BASE_CYC);
    end
  endtask

  task automatic test_saturation();
    run_layer(1'b0, 16'd32767, 16'd32767, 16'd32767, 16'd0, 1'b0, 0);
    for (int i = 0; i < NN; i++) begin
      checks++;
      if (got_data[i] !== 16'h7FFF) begin
        errors++; $display("FAIL sat_pos[%0d]: got %0h, required 7fff", i, got_data[i]);
      end
    end
    run_layer(1'b0, 16'd32767, 16'd32767, 16'h8001, 16'd0, 1'b0, 0);
    for (int i = 0; i < NN; i++) begin
      checks++;
      if (got_data[i] !== 16'h8000) begin
        errors++; $display("FAIL sat_neg[%0d]: got %0h, required 8000", i, got_data[i]);
      end
    end
  endtask

  task automatic test_bias_relu();
    run_layer(1'b0, 16'd1024, 16'd1024, 16'hFFC0, 16'd512, 1'b0, 0);
    for (int i = 0; i < NN; i += 5) begin
      checks++;
      if (got_data[i] !== 16'hF200) begin
        errors++; $display("FAIL bias_linear[%0d]: got %0h, required f200", i, got_data[i]);
      end
    end
    run_layer(1'b1, 16'd1024, 16'd1024, 16'hFFC0, 16'd512, 1'b0, 0);
    for (int i = 0; i < NN; i += 5) begin
      checks++;
      if (got_data[i] !== 16'h0000) begin
        errors++; $display("FAIL bias_relu[%0d]: got %0h, required 0", i, got_data[i]);
      end
    end
  endtask

  task automatic test_rounding();
    run_layer(1'b0, 16'd1, 16'd0, 16'd512, 16'd0, 1'b0, 0);
    checks++;
    if (got_data[3] !== 16'd1) begin
      errors++; $display("FAIL round_half_up: got %0h, required 1", got_data[3]);
    end
    run_layer(1'b0, 16'd1, 16'd0, 16'd511, 16'd0, 1'b0, 0);
    checks++;
    if (got_data[3] !== 16'd0) begin
      errors++; $display("FAIL round_below_half: got %0h, required 0", got_data[3]);
    end
    run_layer(1'b0, 16'd1, 16'd0, 16'hFE00, 16'd0, 1'b0, 0);
    checks++;
    if (got_data[3] !== 16'd0) begin
      errors++; $display("FAIL round_neg_half: got %0h, required 0", got_data[3]);
    end
  endtask

  task automatic test_back_to_back_stalls();
    run_layer(1'b0, 16'd1024, 16'd1024, 16'd64, 16'd0, 1'b1, 3);
    for (int i = 0; i < NN; i++) begin
      checks++;
      if (got_data[i] !== 16'd4096 || got_idx[i] !== 4'(i)) begin
        errors++;
        $display("FAIL stall_out[%0d]: got %0d idx %0d, required 4096 idx %0d", i, got_data[i], got_idx[i], i);
      end
    end
    checks++;
    if (got_unstable !== 0) begin
      errors++; $display("FAIL stall_stable: got %0d changes while held, required 0", got_unstable);
    end
    checks++;
    if (got_cyc + 1 !== BASE_CYC + got_stall || got_stall < NN * 3) begin
      errors++;
      $display("FAIL stall_cycles: got %0d, required %0d (stalls %0d)", got_cyc + 1, BASE_CYC + got_stall, got_stall);
    end
    checks++;
    if (got_done !== 1) begin
      errors++; $display("FAIL stall_done: got %0d done pulses, required 1", got_done);
    end
  endtask

  task automatic test_abort();
    int   macs = 0;
    int   t = 0;
    logic prev = 1'b0;
    in_valid = 1'b1; b_valid = 1'b1; w_valid = 1'b1; out_ready = 1'b1;
    in_data = 16'd1024; b_data = '0; w_data = {NL{16'd64}};
    @(negedge clk); start = 1'b1; mode = 1'b0;
    @(negedge clk); start = 1'b0;
    while (macs < 3 && t < 2000) begin
      if (w_ready && !prev) macs++;
      prev = w_ready;
      t++;
      if (macs < 3) @(negedge clk);
    end
    checks++;
    if (macs !== 3) begin
      errors++; $display("FAIL abort_reach_mac: got %0d MAC phases, required 3", macs);
    end
    repeat (5) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (w_ready !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL start_ignored: w_rdy=%0b in_rdy=%0b busy=%0b, required 1 0 1", w_ready, in_ready, busy);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, out_valid, w_ready, in_ready, b_ready, done, out_data, out_idx} !== '0) begin
      errors++;
      $display("FAIL abort_reset: busy=%0b out_vld=%0b w_rdy=%0b data=%0h idx=%0d, all required 0",
               busy, out_valid, w_ready, out_data, out_idx);
    end
    reset = 1'b0;
    in_valid = 1'b0; b_valid = 1'b0; w_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    run_layer(1'b0, 16'd1024, 16'd1024, 16'd64, 16'd0, 1'b0, 0);
    for (int i = 0; i < NN; i++) begin
      checks++;
      if (got_data[i] !== 16'd4096 || got_idx[i] !== 4'(i)) begin
        errors++;
        $display("FAIL rerun_out[%0d]: got %0d idx %0d, required 4096 idx %0d", i, got_data[i], got_idx[i], i);
      end
    end
    checks++;
    if (got_done !== 1 || got_cyc + 1 !== BASE_CYC) begin
      errors++;
      $display("FAIL rerun_done_cycles: done %0d cycles %0d, required 1 and %0d", got_done, got_cyc + 1, BASE_CYC);
    end
  endtask

  initial begin
    test_reset();
    test_linear();
    test_saturation();
    test_bias_relu();
    test_rounding();
    test_back_to_back_stalls();
    test_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
